ibu_pipe: RTL and testbench
===========================

// Module: ibu_pipe
// PURPOSE
//  Pipelined inverse (Gentleman-Sande) butterfly for the INTT datapath; undoes the forward modular butterfly.
//  Per beat: R0_out = (R0_in + R1_in) * 2^-1 mod N_in and R1_out = (R0_in - R1_in) * 2^-1 mod N_in.
//  Halving is optional via HALVE, so 1/n scaling is spread over the log2(n) INTT stages.
//  Sits between INTT stage buffers, with valid/ready handshakes on both sides.
// PARAMETERS
//  D_WIDTH  64  coefficient / modulus width in bits
//  HALVE    1   1: multiply both results by 2^-1 mod N; 0: plain modular add/sub
// PORTS
//  clk        in   1        single clock, rising edge
//  rst        in   1        asynchronous, active-high reset
//  in_valid   in   1        input beat valid
//  in_ready   out  1        block accepts a beat this cycle
//  R0_in      in   D_WIDTH  operand a, must be < N_in
//  R1_in      in   D_WIDTH  operand b, must be < N_in
//  N_in       in   D_WIDTH  odd modulus, sampled per beat (travels with the data)
//  out_valid  out  1        output beat valid
//  out_ready  in   1        downstream accepts the beat
//  R0_out     out  D_WIDTH  (a+b)/2 mod N, or (a+b) mod N if HALVE=0
//  R1_out     out  D_WIDTH  (a-b)/2 mod N, or (a-b) mod N if HALVE=0
// BEHAVIOUR
//  Reset: s1_valid, s2_valid and out_valid = 0; all data registers = 0, so R0_out = R1_out = 0.
//    in_ready = 1 after reset.
//  Pipeline: two register stages, S1 and S2. Latency 2 cycles from accept to out_valid when unstalled.
//    Throughput is 1 beat per cycle.
//  S1 (on accept): compute in D_WIDTH+1 bits.
//    s = a+b; store s-N if s>=N, else s.
//    d = a + (N-b); store d-N if d>=N, else d.
//    Store N alongside.
//  S2: if HALVE=1, halve each value x: x even -> x>>1; x odd -> (x+N)>>1.
//    x+N is computed in D_WIDTH+1 bits; no overflow is lost.
//    If HALVE=0, pass through. R0_out/R1_out are driven directly from the S2 registers.
//  Handshake:
//    s2_adv = !s2_valid | out_ready
//    s1_adv = !s1_valid | s2_adv
//    in_ready = s1_adv (combinational ready chain; no skid buffer)
//  Transfers: input transfer = in_valid & in_ready; output transfer = out_valid & out_ready.
//  Stall: while out_valid & !out_ready, R0_out/R1_out/out_valid hold stable.
//    A bubble in S2 is still filled from S1.
//  Simultaneous events: an output transfer, an S1->S2 move and a new input accept may all happen in one cycle.
//    No beat may be lost or duplicated.
//  Ordering: beats leave strictly in input order.
//  in_valid dropping while !in_ready is legal. Data is sampled only on a transfer.
//  Reset mid-operation: all in-flight beats are discarded. out_valid = 0 on the cycle after rst asserts.
//  Out-of-range inputs (a>=N, b>=N, or N even) are a caller error. Results are unspecified; no hang is allowed.
// TESTING
//  1. N=17, a=3, b=5, HALVE=1 -> R0_out=4, R1_out=16; out_valid 2 cycles after accept.
//  2. N=0xFFFFFFFF00000001, a=b=N-1 -> R0_out=N-1, R1_out=0 (checks the 65-bit carry path).
//  3. Stream 100 random beats with out_ready held 1 -> one result per cycle, in order,
//     matching the model (a±b)*inv2 mod N.
//  4. Random out_ready (50%) plus random in_valid -> no loss, no duplication, outputs stable while stalled.
//     in_ready = 0 only when both stages are full and out_ready = 0.
//  5. Assert rst with 2 beats in flight -> out_valid = 0 next cycle. After release, in_ready = 1 and no stale beat appears.
//  6. HALVE=0, N=17, a=3, b=5 -> R0_out=8, R1_out=15; a=0, b=0 -> 0, 0 (d=N wraps to 0).

Source files
------------

// File: rtl/ibu_pipe.sv
// rtl/ibu_pipe.sv - two-stage pipelined inverse (Gentleman-Sande) modular butterfly
// S1 does the modular add/sub, S2 the optional multiply by 2^-1 mod N.
module ibu_pipe #(
    parameter int D_WIDTH = 64,
    parameter bit HALVE   = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [D_WIDTH-1:0] R0_in,
    input  logic [D_WIDTH-1:0] R1_in,
    input  logic [D_WIDTH-1:0] N_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [D_WIDTH-1:0] R0_out,
    output logic [D_WIDTH-1:0] R1_out
);

    logic               s1_valid_q, s2_valid_q;
    logic [D_WIDTH-1:0] s1_r0_q, s1_r1_q, s1_n_q;
    logic [D_WIDTH-1:0] s2_r0_q, s2_r1_q;
    logic [D_WIDTH-1:0] s1_r0_d, s1_r1_d, s2_r0_d, s2_r1_d;
    logic [D_WIDTH-1:0] n_minus_b, sum_lo, dif_lo;
    logic [D_WIDTH:0]   sum_w, dif_w, n_ext;
    logic               s1_adv, s2_adv;

    // (x + N) >> 1 for odd x and odd N, split so no carry bit is dropped
    function automatic logic [D_WIDTH-1:0] half_mod(input logic [D_WIDTH-1:0] x,
                                                    input logic [D_WIDTH-1:0] n);
        if (!HALVE)
            return x;
        else if (x[0])
            return (x >> 1) + (n >> 1) + {{(D_WIDTH-1){1'b0}}, 1'b1};
        else
            return x >> 1;
    endfunction

    always_comb begin
        s2_adv   = !s2_valid_q || out_ready;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = s1_adv;

        // the wide sums only decide the reduction; the low bits carry the value
        n_ext     = {1'b0, N_in};
        n_minus_b = N_in - R1_in;
        sum_w     = {1'b0, R0_in} + {1'b0, R1_in};
        dif_w     = {1'b0, R0_in} + {1'b0, n_minus_b};
        sum_lo    = R0_in + R1_in;
        dif_lo    = R0_in + n_minus_b;
        s1_r0_d   = (sum_w >= n_ext) ? sum_lo - N_in : sum_lo;
        s1_r1_d   = (dif_w >= n_ext) ? dif_lo - N_in : dif_lo;

        s2_r0_d   = half_mod(s1_r0_q, s1_n_q);
        s2_r1_d   = half_mod(s1_r1_q, s1_n_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_r0_q    <= '0;
            s1_r1_q    <= '0;
            s1_n_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_r0_q    <= '0;
            s2_r1_q    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_r0_q <= s1_r0_d;
                    s1_r1_q <= s1_r1_d;
                    s1_n_q  <= N_in;
                end
            end
            if (s2_adv) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_r0_q <= s2_r0_d;
                    s2_r1_q <= s2_r1_d;
                end
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign R0_out    = s2_r0_q;
    assign R1_out    = s2_r1_q;

endmodule

// File: tb/tb_ibu_pipe.sv
// tb/tb_ibu_pipe.sv - self-checking bench for ibu_pipe (HALVE=1 and HALVE=0 instances)
module tb_ibu_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] R0_in, R1_in, N_in;
    logic        in_ready_h, out_valid_h, in_ready_p, out_valid_p;
    logic [63:0] r0_h, r1_h, r0_p, r1_p;

    int n_cmp = 0;
    int n_err = 0;
    int n_in  = 0;
    int n_out = 0;

    logic [63:0] q_r0[$], q_r1[$], qp_r0[$], qp_r1[$];
    bit          prev_stall;
    logic [63:0] prev_r0, prev_r1;

    always #5 clk = ~clk;

    ibu_pipe #(.D_WIDTH(64), .HALVE(1'b1)) u_h (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
        .R0_in(R0_in), .R1_in(R1_in), .N_in(N_in),
        .out_valid(out_valid_h), .out_ready(out_ready),
        .R0_out(r0_h), .R1_out(r1_h)
    );

    ibu_pipe #(.D_WIDTH(64), .HALVE(1'b0)) u_p (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_p),
        .R0_in(R0_in), .R1_in(R1_in), .N_in(N_in),
        .out_valid(out_valid_p), .out_ready(out_ready),
        .R0_out(r0_p), .R1_out(r1_p)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // x * 2^-1 mod n, using the explicit inverse (n+1)/2 of an odd modulus
    function automatic logic [63:0] ref_mod(input logic [127:0] x, input logic [63:0] n,
                                            input bit h);
        logic [127:0] inv2, n_w, r;
        n_w  = {64'd0, n};
        inv2 = (n_w + 128'd1) >> 1;
        r    = h ? (x * inv2) % n_w : x % n_w;
        return r[63:0];
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] rand_mod();
        case ($urandom_range(0, 2))
            0:       return 64'($urandom_range(3, 1000)) | 64'd1;
            1:       return rand64() | 64'h8000_0000_0000_0001;
            default: return 64'hFFFF_FFFF_0000_0001;
        endcase
    endfunction

    // one clock of random traffic; checks run at negedge+1 against the queue model
    task automatic run_cycle(input int pin, input int pout);
        logic [127:0] a_w, b_w, n_w;
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", 64'(out_valid_h), 64'd1);
            check("hold_r0", r0_h, prev_r0);
            check("hold_r1", r1_h, prev_r1);
        end
        out_ready = ($urandom_range(0, 99) < pout);
        in_valid  = ($urandom_range(0, 99) < pin);
        if (in_valid) begin
            N_in  = rand_mod();
            R0_in = rand64() % N_in;
            R1_in = rand64() % N_in;
        end
        #1;
        check("in_ready", 64'(in_ready_h), 64'(!(q_r0.size() == 2 && !out_ready)));
        check("in_ready_p", 64'(in_ready_p), 64'(in_ready_h));
        check("valid_p", 64'(out_valid_p), 64'(out_valid_h));
        if (out_valid_h)
            check("no_dup", 64'(q_r0.size() != 0), 64'd1);
        if (out_valid_h && out_ready && q_r0.size() != 0) begin
            check("r0", r0_h, q_r0.pop_front());
            check("r1", r1_h, q_r1.pop_front());
            check("r0_p", r0_p, qp_r0.pop_front());
            check("r1_p", r1_p, qp_r1.pop_front());
            n_out++;
        end
        if (in_valid && in_ready_h) begin
            a_w = {64'd0, R0_in};
            b_w = {64'd0, R1_in};
            n_w = {64'd0, N_in};
            q_r0.push_back(ref_mod(a_w + b_w, N_in, 1'b1));
            q_r1.push_back(ref_mod(a_w + n_w - b_w, N_in, 1'b1));
            qp_r0.push_back(ref_mod(a_w + b_w, N_in, 1'b0));
            qp_r1.push_back(ref_mod(a_w + n_w - b_w, N_in, 1'b0));
            n_in++;
        end
        prev_stall = out_valid_h && !out_ready;
        prev_r0    = r0_h;
        prev_r1    = r1_h;
    endtask

    // single beat into an empty pipe: out_valid must rise exactly two cycles after accept
    task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                            input logic [63:0] n, input logic [63:0] e0, input logic [63:0] e1,
                            input logic [63:0] p0, input logic [63:0] p1);
        @(negedge clk);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        R0_in     = a;
        R1_in     = b;
        N_in      = n;
        #1;
        check({tag, "_accept"}, 64'(in_ready_h), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_lat1"}, 64'(out_valid_h), 64'd0);
        @(negedge clk);
        check({tag, "_valid"}, 64'(out_valid_h), 64'd1);
        check({tag, "_r0"}, r0_h, e0);
        check({tag, "_r1"}, r1_h, e1);
        check({tag, "_r0_nohalve"}, r0_p, p0);
        check({tag, "_r1_nohalve"}, r1_p, p1);
        @(negedge clk);
        check({tag, "_drained"}, 64'(out_valid_h), 64'd0);
    endtask

    initial begin
        int start_out;
        rst        = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        R0_in      = '0;
        R1_in      = '0;
        N_in       = 64'd17;
        prev_stall = 1'b0;
        prev_r0    = '0;
        prev_r1    = '0;

        repeat (2) @(negedge clk);
        check("rst_valid", 64'(out_valid_h), 64'd0);
        check("rst_r0", r0_h, 64'd0);
        check("rst_r1", r1_h, 64'd0);
        check("rst_in_ready", 64'(in_ready_h), 64'd1);
        rst = 1'b0;

        directed("n17", 64'd3, 64'd5, 64'd17, 64'd4, 64'd16, 64'd8, 64'd15);
        directed("n17_zero", 64'd0, 64'd0, 64'd17, 64'd0, 64'd0, 64'd0, 64'd0);
        directed("carry", 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000,
                 64'hFFFF_FFFF_0000_0001, 64'hFFFF_FFFF_0000_0000, 64'd0,
                 64'hFFFF_FFFE_FFFF_FFFF, 64'd0);

        // full-rate stream: 100 beats must emerge in exactly 100+2 cycles
        start_out = n_out;
        repeat (100) run_cycle(100, 100);
        repeat (2) run_cycle(0, 100);
        check("stream_count", 64'(n_out - start_out), 64'd100);
        check("stream_empty", 64'(q_r0.size()), 64'd0);

        // random backpressure and random arrivals
        repeat (600) run_cycle(60, 50);
        repeat (6) run_cycle(0, 100);
        check("rand_drain", 64'(q_r0.size()), 64'd0);
        check("rand_count", 64'(n_out), 64'(n_in));

        // reset with two beats in flight
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        R0_in     = 64'd1;
        R1_in     = 64'd2;
        N_in      = 64'd17;
        @(negedge clk);
        R0_in = 64'd7;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_valid", 64'(out_valid_h), 64'd1);
        check("pre_rst_ready", 64'(in_ready_h), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_valid", 64'(out_valid_h), 64'd0);
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_ready", 64'(in_ready_h), 64'd1);
        q_r0.delete();
        q_r1.delete();
        qp_r0.delete();
        qp_r1.delete();
        prev_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale", 64'(out_valid_h), 64'd0);
        end

        // traffic resumes cleanly after reset
        n_in  = 0;
        n_out = 0;
        repeat (100) run_cycle(70, 60);
        repeat (6) run_cycle(0, 100);
        check("post_rst_count", 64'(n_out), 64'(n_in));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
